// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field layout, fetch FSM encoding and the
// opcodes the control unit decodes.
package cpu_pkg;

  localparam int INSTR_W    = 32;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  // Plain constants mirror the enum so legacy code and checkers can compare raw bits.
  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b111000;

  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// One-entry skid holding a fetched instruction and its address while the
// decode slot is occupied. Flush wins over load, load wins over unload.
module fetch_buffer
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic               i_unload,
  input  logic               i_flush,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [31:0]        i_pc,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [31:0]        o_pc
);

  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [31:0]        r_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_unload) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues one instruction-memory request at a time and
// presents the fetched word to decode through a registered slot plus a skid entry.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [31:0]         imem_addr,
  input  logic                imem_ready,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                id_ready,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  output logic                if_valid,
  output logic [INSTR_W-1:0]  if_instr,
  output logic [OPCODE_W-1:0] if_opcode,
  output logic [31:0]         if_pc,
  output logic [31:0]         if_pc_plus4,
  output logic [1:0]          dbg_state
);

  // Handshakes: imem_req stays high with a stable imem_addr until the single-cycle
  // imem_ready pulse retires it; decode takes the slot on any cycle with
  // if_valid && id_ready, and the slot is never replaced before that.
  logic [1:0]         r_state;
  logic [31:0]        r_pc;
  logic [31:0]        r_addr;
  logic               r_if_valid;
  logic [INSTR_W-1:0] r_if_instr;
  logic [31:0]        r_if_pc;
  logic [31:0]        r_if_pc_plus4;

  logic               w_consume;
  logic               w_resp;
  logic               w_to_slot;
  logic               w_to_skid;
  logic               w_skid_unload;
  logic               w_skid_valid;
  logic [INSTR_W-1:0] w_skid_instr;
  logic [31:0]        w_skid_pc;
  logic [31:0]        w_pc_plus4;

  assign w_consume     = r_if_valid && id_ready;
  assign w_resp        = (r_state == ST_WAIT) && imem_ready && !redirect;
  assign w_to_slot     = w_resp && (!r_if_valid || w_consume);
  assign w_to_skid     = w_resp && !w_to_slot;
  assign w_skid_unload = w_consume && w_skid_valid && !redirect;
  assign w_pc_plus4    = r_pc + 32'd4;

  fetch_buffer u_skid (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_to_skid),
    .i_unload (w_skid_unload),
    .i_flush  (redirect),
    .i_instr  (imem_rdata),
    .i_pc     (r_pc),
    .o_valid  (w_skid_valid),
    .o_instr  (w_skid_instr),
    .o_pc     (w_skid_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_FETCH;
      r_pc    <= RESET_PC;
      r_addr  <= '0;
    end else if (redirect) begin
      // An outstanding request must still be retired; its data is thrown away.
      r_pc <= redirect_pc;
      if (r_state != ST_FETCH) r_state <= imem_ready ? ST_FETCH : ST_DRAIN;
    end else begin
      case (r_state)
        ST_FETCH: if (!w_skid_valid) begin
          r_state <= ST_WAIT;
          r_addr  <= r_pc;
        end
        ST_WAIT: if (imem_ready) begin
          r_state <= ST_FETCH;
          r_pc    <= w_pc_plus4;
        end
        ST_DRAIN: if (imem_ready) r_state <= ST_FETCH;
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_if_valid    <= 1'b0;
      r_if_instr    <= '0;
      r_if_pc       <= '0;
      r_if_pc_plus4 <= '0;
    end else if (redirect) begin
      r_if_valid <= 1'b0;
    end else if (w_to_slot) begin
      r_if_valid    <= 1'b1;
      r_if_instr    <= imem_rdata;
      r_if_pc       <= r_pc;
      r_if_pc_plus4 <= w_pc_plus4;
    end else if (w_skid_unload) begin
      r_if_valid    <= 1'b1;
      r_if_instr    <= w_skid_instr;
      r_if_pc       <= w_skid_pc;
      r_if_pc_plus4 <= w_skid_pc + 32'd4;
    end else if (w_consume) begin
      r_if_valid <= 1'b0;
    end
  end

  assign imem_req    = (r_state == ST_WAIT) || (r_state == ST_DRAIN);
  assign imem_addr   = r_addr;
  assign if_valid    = r_if_valid;
  assign if_instr    = r_if_instr;
  assign if_opcode   = opcode_of(r_if_instr);
  assign if_pc       = r_if_pc;
  assign if_pc_plus4 = r_if_pc_plus4;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: transaction-level queue model, randomized memory
// latency / stalls / redirects / resets, and directed scenarios with literal pins.
module tb_instruction_fetch;
  import cpu_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        id_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [5:0]  if_opcode;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [1:0]  dbg_state;

  instruction_fetch #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .id_ready    (id_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_opcode   (if_opcode),
    .if_pc       (if_pc),
    .if_pc_plus4 (if_pc_plus4),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- model state ----------------
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t      m_q[$];        // front = decode slot, second entry = skid
  logic [31:0] m_pc   = RST_PC;
  logic [31:0] m_addr = '0;
  int          m_out  = 0;    // 0 no request, 1 wanted, 2 discarded

  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // stimulus knobs
  int k_dmin = 0, k_dmax = 0, k_rdy = 100, k_redir = 0, k_rst = 0;
  logic        f_reset = 1'b0, f_redir = 1'b0;
  logic [31:0] f_pc = '0;
  logic        mem_busy = 1'b0;
  int          mem_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    logic [5:0]  op;
    h = (a ^ 32'h5bd1_e995) * 32'h9e37_79b1;
    case (h[1:0])
      2'd0:    op = OP_RTYPE;
      2'd1:    op = OP_LW;
      2'd2:    op = OP_J;
      default: op = h[31:26];
    endcase
    return {op, h[27:2]};
  endfunction

  // ---------------- reference model ----------------
  task automatic model_update();
    if (reset) begin
      m_pc = RST_PC; m_out = 0; m_addr = '0; m_q.delete();
    end else if (redirect) begin
      m_q.delete();
      m_pc = redirect_pc;
      m_out = (m_out != 0 && !imem_ready) ? 2 : 0;
    end else begin
      int n;
      n = m_q.size();
      if (n > 0 && id_ready) void'(m_q.pop_front());
      if (m_out == 1 && imem_ready) begin
        m_q.push_back({imem_rdata, m_pc});
        m_pc  = m_pc + 32'd4;
        m_out = 0;
      end else if (m_out == 2 && imem_ready) begin
        m_out = 0;
      end else if (m_out == 0 && n <= 1) begin
        m_addr = m_pc;
        m_out  = 1;
      end
    end
  endtask

  // ---------------- scoreboard compare ----------------
  task automatic compare();
    logic [1:0] st;
    st = (m_out == 0) ? ST_FETCH : (m_out == 1) ? ST_WAIT : ST_DRAIN;
    check("imem_req", imem_req, (m_out != 0));
    check("dbg_state", dbg_state, st);
    if (m_out != 0) check("imem_addr", imem_addr, m_addr);
    check("if_valid", if_valid, (m_q.size() != 0));
    if (m_q.size() != 0) begin
      check("if_instr", if_instr, m_q[0].instr);
      check("if_opcode", if_opcode, m_q[0].instr[31:26]);
      check("if_pc", if_pc, m_q[0].pc);
      check("if_pc_plus4", if_pc_plus4, m_q[0].pc + 32'd4);
    end
  endtask

  // ---------------- driver: one cycle ----------------
  task automatic step();
    compare();
    reset       = f_reset || ($urandom_range(999) < k_rst);
    redirect    = f_redir || ($urandom_range(99) < k_redir);
    redirect_pc = f_redir ? f_pc : ($urandom() & 32'hFFFF_FFFC);
    id_ready    = ($urandom_range(99) < k_rdy);
    if (imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_cnt  = $urandom_range(k_dmax, k_dmin);
      end
      if (mem_cnt == 0) begin
        imem_ready = 1'b1;
        imem_rdata = mem_word(imem_addr);
        mem_busy   = 1'b0;
      end else begin
        mem_cnt--;
        imem_ready = 1'b0;
        imem_rdata = $urandom();
      end
    end else begin
      mem_busy   = 1'b0;
      imem_ready = 1'b0;
      imem_rdata = $urandom();
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    f_reset = 1'b1;
    step();
    step();
    f_reset = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_req(input logic [31:0] a);
    int n;
    n = 0;
    while (!(imem_req === 1'b1 && imem_addr === a) && n < 40) begin
      step();
      n++;
    end
    check("wait_req", (imem_req === 1'b1 && imem_addr === a), 32'd1);
  endtask

  task automatic wait_valid_pc(input logic [31:0] a);
    int n;
    n = 0;
    while (!(if_valid === 1'b1 && if_pc === a) && n < 40) begin
      step();
      n++;
    end
    check("wait_valid_pc", (if_valid === 1'b1 && if_pc === a), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] w;
    @(posedge clk);
    @(negedge clk);

    // Zero-wait memory, decode always ready: 0x100, 0x104, 0x108 at cycles 2, 4, 6.
    do_reset();
    exp_q = '{32'h100, 32'h104, 32'h108};
    for (int c = 0; c < 8; c++) begin
      if (c == 0) begin
        check("rst_req", imem_req, 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_valid", if_valid, 32'd0);
        check("rst_instr", if_instr, 32'd0);
        check("rst_opcode", if_opcode, 32'd0);
        check("rst_pc", if_pc, 32'd0);
        check("rst_pc_plus4", if_pc_plus4, 32'd0);
      end
      if (c == 1 || c == 3) check("req_cycle", imem_req, 32'd1);
      if (c == 1) check("first_addr", imem_addr, 32'h100);
      if (c == 3 || c == 5) check("gap_cycle", if_valid, 32'd0);
      if (c == 2 || c == 4 || c == 6) begin
        check("seq_valid", if_valid, 32'd1);
        check("seq_pc", if_pc, exp_q.pop_front());
      end
      if (c == 2) begin
        w = mem_word(32'h100);
        check("seq_opcode", if_opcode, w[31:26]);
        check("seq_plus4", if_pc_plus4, 32'h104);
      end
      step();
    end

    // Decode stalls cycles 2..6: second word parks in the skid, no third request.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      k_rdy = (c >= 2 && c <= 6) ? 0 : 100;
      if (c >= 2 && c <= 7) begin
        check("stall_valid", if_valid, 32'd1);
        check("stall_pc", if_pc, 32'h100);
      end
      if (c >= 4 && c <= 7) check("stall_no_req", imem_req, 32'd0);
      if (c == 8) begin
        check("skid_valid", if_valid, 32'd1);
        check("skid_pc", if_pc, 32'h104);
      end
      step();
    end
    k_rdy = 100;

    // Redirect to 0x400 while the 0x108 request waits three cycles.
    do_reset();
    wait_req(32'h108);
    k_dmin = 3; k_dmax = 3;
    f_redir = 1'b1; f_pc = 32'h400;
    step();
    f_redir = 1'b0;
    check("drain_valid", if_valid, 32'd0);
    for (int c = 1; c <= 3; c++) begin
      check("drain_req", imem_req, 32'd1);
      check("drain_addr", imem_addr, 32'h108);
      step();
    end
    check("drain_done_req", imem_req, 32'd0);
    step();
    check("redir_req", imem_req, 32'd1);
    check("redir_addr", imem_addr, 32'h400);
    k_dmin = 0; k_dmax = 0;

    // Redirect in the same cycle as the response: word dropped, straight to FETCH.
    wait_req(32'h404);
    f_redir = 1'b1; f_pc = 32'h800;
    step();
    f_redir = 1'b0;
    check("coinc_valid", if_valid, 32'd0);
    check("coinc_req", imem_req, 32'd0);
    step();
    check("coinc_next_req", imem_req, 32'd1);
    check("coinc_next_addr", imem_addr, 32'h800);

    // PC wrap at the top of the address space.
    f_redir = 1'b1; f_pc = 32'hFFFF_FFFC;
    step();
    f_redir = 1'b0;
    wait_req(32'hFFFF_FFFC);
    wait_valid_pc(32'hFFFF_FFFC);
    check("wrap_plus4", if_pc_plus4, 32'h0);
    wait_req(32'h0);

    // Reset while a request is outstanding.
    k_dmin = 3; k_dmax = 3;
    wait_req(32'h4);
    f_reset = 1'b1;
    step();
    f_reset = 1'b0;
    check("wait_rst_req", imem_req, 32'd0);
    check("wait_rst_valid", if_valid, 32'd0);
    check("wait_rst_addr", imem_addr, 32'd0);
    step();
    check("wait_rst_next_req", imem_req, 32'd1);
    check("wait_rst_next_addr", imem_addr, RST_PC);
    k_dmin = 0; k_dmax = 0;

    // Randomized traffic.
    k_dmin = 0; k_dmax = 3; k_rdy = 70; k_redir = 4; k_rst = 5;
    repeat (1500) step();
    k_dmax = 1; k_rdy = 20; k_redir = 2;
    repeat (1000) step();
    k_dmax = 0; k_rdy = 100; k_redir = 10; k_rst = 0;
    repeat (800) step();
    compare();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage that owns the program counter, drives a ready-handshaked instruction-memory port, and presents one fetched instruction (with its 6-bit opcode field) to the decode/control stage. Sits directly upstream of the control unit: `if_opcode` feeds its `opcode` input. A one-entry skid buffer absorbs a response that arrives while decode is stalled. A redirect input (branch/jump/jr target resolved downstream) flushes in-flight work.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- imem_req  out  1  request valid; held high until `imem_ready`
- imem_addr  out  32  byte address of request; stable while `imem_req`
- imem_ready  in  1  one-cycle pulse: `imem_rdata` valid, request retired
- imem_rdata  in  32  instruction word
- id_ready  in  1  decode accepts the current instruction this cycle (low = stall)
- redirect  in  1  one-cycle pulse: discard fetched and in-flight instructions
- redirect_pc  in  32  new fetch address, sampled when `redirect`
- if_valid  out  1  `if_instr`/`if_pc` hold a valid instruction
- if_instr  out  32  instruction word
- if_opcode  out  6  `if_instr[31:26]`
- if_pc  out  32  address of `if_instr`
- if_pc_plus4  out  32  `if_pc + 4`, modulo 2^32

## Operation
- State is held in `pc` (next fetch address), `state`, the output slot (`if_*`), and a skid entry (valid, instr, pc).
- States:
  - FETCH: no request outstanding.
  - WAIT: request outstanding, response wanted.
  - DRAIN: request outstanding, response to be discarded.
- `imem_req = (state==WAIT || state==DRAIN)`, and `imem_addr` is a registered copy of the issue address.
- FETCH -> WAIT when skid empty and no `redirect`. Latch `imem_addr <= pc`.
- WAIT with `imem_ready`:
  - Word goes to the slot if slot empty or `id_ready && if_valid`; otherwise it goes to skid.
  - `pc <= pc + 4` (wraps at 2^32).
  - Next state: FETCH.
- Slot consumed (`if_valid && id_ready`) with skid valid: skid moves to slot, skid clears.
- Slot consumed with nothing arriving: `if_valid <= 0`.
- Redirect (highest priority):
  - `pc <= redirect_pc`; `if_valid <= 0`; skid clears.
  - FETCH stays FETCH.
  - WAIT goes to DRAIN, or to FETCH if `imem_ready` is high the same cycle (that response is dropped).
  - DRAIN stays DRAIN.
- DRAIN with `imem_ready`: drop data, go to FETCH. A redirect in DRAIN only updates `pc`.
- `id_ready` while `if_valid=0` has no effect. The slot is never overwritten while valid and not consumed.

## Timing
- Reset values:
  - `pc=RESET_PC`, state FETCH, `imem_req=0`, `imem_addr=0`.
  - `if_valid=0`, `if_instr=0`, `if_opcode=0`, `if_pc=0`, `if_pc_plus4=0`, skid empty.
- Reset mid-request abandons the request. The memory model must tolerate `imem_req` dropping without `imem_ready`.
- All outputs are registered, with no combinational path from inputs to outputs.
- Latency:
  - Cycle 0: first cycle after reset release, FETCH.
  - Cycle 1: `imem_req` high.
  - A response at cycle 1+k gives `if_valid` at cycle 2+k.
- Zero-wait memory with `id_ready` held high sustains one instruction per 2 cycles.
- Redirect at cycle n: `if_valid=0` at n+1; request to `redirect_pc` no earlier than n+2, or later if draining.

## Structure
- Shared package (`cpu_pkg`):
  - Fetch state enum (FETCH/WAIT/DRAIN).
  - `OPCODE_MSB=31`, `OPCODE_LSB=26`, `INSTR_W=32`.
  - The opcode constants the control unit decodes (R-type 000000, lw 001000, j 111000, …), so benches and decode share one source.
- One natural sub-module: `fetch_buffer`, a one-entry skid (valid/instr/pc) with load/unload/flush.

## Test plan
- Reset, RESET_PC=0x100, memory answers the cycle after req, `id_ready=1` -> `if_pc` sequence 0x100, 0x104, 0x108; `if_opcode` matches `imem_rdata[31:26]`; one instruction per 2 cycles.
- `id_ready=0` for 5 cycles after the first instruction -> slot holds 0x100, second word goes to skid, no third request; on release 0x104 appears next cycle.
- Redirect to 0x400 while a request to 0x108 waits 3 cycles -> `if_valid=0` next cycle, `imem_addr` stays 0x108 until ready, response dropped, next request is 0x400.
- Redirect coincident with `imem_ready` in WAIT -> word dropped, FETCH, next request is `redirect_pc`.
- `pc=0xFFFF_FFFC` fetch -> `if_pc_plus4=0`, next request address 0x0.
- Assert reset during WAIT -> next cycle `imem_req=0`, `if_valid=0`, `pc=RESET_PC`.
